window_minmax_tracker: RTL and testbench
========================================

Name: window_minmax_tracker

Overview:
Streaming stage that consumes unsigned WIDTH-bit samples over a valid/ready handshake and produces the running maximum and minimum of each WINDOW-sample block. Ordering is by unsigned magnitude, with the eq/lt/gt semantics of the team's 8-bit magnitude comparator. Downstream checkers consume the emitted (max, min, span) result as one handshaked beat. Sits directly downstream of the sample source and upstream of the comparator-based limit checkers.

Parameters:
WIDTH, 8, sample width in bits (unsigned)
WINDOW, 16, samples per result block; legal range 1..255

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort of current window; discard partial results
in_valid  in  1  sample present
in_ready  out  1  stage accepts sample this cycle
in_data  in  WIDTH  sample value, unsigned
out_valid  out  1  result beat present
out_ready  in  1  downstream accepts result
out_max  out  WIDTH  largest sample in the window
out_min  out  WIDTH  smallest sample in the window
out_span  out  WIDTH  out_max - out_min (never negative)

Behaviour:
- Reset (rst_n=0, asynchronous): state=FIRST; count=0; max_r=0; min_r=0.
- Reset outputs: out_valid=0; out_max=0; out_min=0; out_span=0; in_ready=1 (once released).
- Reset mid-window or mid-hold discards everything. No result is emitted for a partial window.
- Accept event: in_valid & in_ready at the rising edge.
- FSM states: FIRST, ACCUM, HOLD.
- FIRST:
  - in_ready=1.
  - On accept: max_r=min_r=in_data; count=1.
  - If WINDOW==1, go to HOLD; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept: if in_data > max_r (gt), max_r=in_data. If in_data < min_r (lt), min_r=in_data. Equal values leave both registers unchanged. count += 1.
  - When count reaches WINDOW on this accept, go to HOLD.
- HOLD:
  - in_ready=0; out_valid=1.
  - out_max, out_min and out_span are registered and held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid drops the next cycle; count=0; go to FIRST.
- Latency: out_valid rises on the clock edge that accepts the WINDOW-th sample, so it is visible the following cycle. The result includes that final sample.
- No bypass: a sample offered in the same cycle as the result handshake is not accepted (in_ready=0). Throughput is WINDOW samples per WINDOW+1 cycles when out_ready=1.
- Arithmetic:
  - All comparisons are unsigned, full WIDTH.
  - span = max - min computed in WIDTH bits; cannot underflow because max >= min.
  - count is an 8-bit counter and never wraps, since WINDOW <= 255.
- clear (synchronous, priority over all handshakes):
  - Next state is FIRST; count=0; out_valid=0.
  - A sample presented in the clear cycle is dropped, not accepted.
  - clear while in HOLD discards the pending result even if out_ready=1 in that cycle.
- in_data is ignored when in_valid=0. out_* holds its last value after the handshake until the next result; it is only meaningful while out_valid=1.
- in_valid may drop between samples (bubbles); count advances only on accepts.

Test Plan:
- WINDOW=4, out_ready=1, samples 10,14,242,246 back-to-back -> out_valid exactly one cycle after the 4th accept; max=246, min=10, span=236; in_ready low for that one cycle.
- WINDOW=4, samples 100,100,100,100 (all eq) -> max=100, min=100, span=0.
- WINDOW=4, samples 255,0,128,1 with in_valid bubbles between each -> max=255, min=0, span=255; out_valid only after the 4th accept.
- Backpressure: out_ready=0 for 5 cycles after result, in_valid held high with 7 -> in_ready=0 and outputs stable throughout. Raise out_ready -> next window starts and 7 is accepted the cycle after the handshake.
- clear asserted after 2 of 4 samples (50,60), then 5,9,3,8 -> result max=9, min=3; no result emitted for 50,60.
- rst_n pulsed low asynchronously while in HOLD -> out_valid drops immediately; all outputs 0; state FIRST. WINDOW=1 build: single sample 77 -> max=min=77, span=0.

Source files
------------

// File: rtl/window_minmax_tracker_if.sv
// Sample-in / result-out handshake bundle for the window min/max tracker.
// The slave modport is the tracker's view; the master modport is the surrounding logic's view.
interface window_minmax_tracker_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_span;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_span
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_min, out_span
    );
endinterface

// File: rtl/window_minmax_tracker.sv
// Tracks the unsigned max/min of each WINDOW-sample block.
// Emits each block's (max, min, span) result as a single handshaked beat.
module window_minmax_tracker #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned WINDOW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    window_minmax_tracker_if.slave bus
);
    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] WINDOW_C = 8'(WINDOW);

    state_t           state_r;
    state_t           next_state_s;
    logic [7:0]       count_r;
    logic [7:0]       count_next_s;
    logic [WIDTH-1:0] max_r;
    logic [WIDTH-1:0] min_r;
    logic [WIDTH-1:0] max_next_s;
    logic [WIDTH-1:0] min_next_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             release_s;
    logic             last_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_max_r;
    logic [WIDTH-1:0] out_min_r;
    logic [WIDTH-1:0] out_span_r;

    function automatic logic mag_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a > b);
    endfunction

    function automatic logic mag_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a < b);
    endfunction

    // Candidate extremes and count if the current offer is accepted
    always_comb begin
        max_next_s   = max_r;
        min_next_s   = min_r;
        count_next_s = count_r + 8'd1;
        if (state_r == ST_FIRST) begin
            max_next_s   = bus.in_data;
            min_next_s   = bus.in_data;
            count_next_s = 8'd1;
        end else begin
            if (mag_gt(bus.in_data, max_r)) begin
                max_next_s = bus.in_data;
            end else begin
                max_next_s = max_r;
            end
            if (mag_lt(bus.in_data, min_r)) begin
                min_next_s = bus.in_data;
            end else begin
                min_next_s = min_r;
            end
        end
        last_s = (count_next_s == WINDOW_C);
    end

    // FSM next-state and handshake decode; clear overrides every handshake
    always_comb begin
        next_state_s = state_r;
        in_ready_s   = 1'b0;
        accept_s     = 1'b0;
        release_s    = 1'b0;
        if (clear) begin
            next_state_s = ST_FIRST;
        end else begin
            case (state_r)
                ST_FIRST, ST_ACCUM: begin
                    in_ready_s = 1'b1;
                    accept_s   = bus.in_valid;
                    if (bus.in_valid && last_s) begin
                        next_state_s = ST_HOLD;
                    end else if (bus.in_valid) begin
                        next_state_s = ST_ACCUM;
                    end else begin
                        next_state_s = state_r;
                    end
                end
                ST_HOLD: begin
                    release_s = bus.out_ready;
                    if (bus.out_ready) begin
                        next_state_s = ST_FIRST;
                    end else begin
                        next_state_s = ST_HOLD;
                    end
                end
                default: begin
                    next_state_s = ST_FIRST;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FIRST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Running extremes and sample count of the open window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
            max_r   <= '0;
            min_r   <= '0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (accept_s) begin
            count_r <= count_next_s;
            max_r   <= max_next_s;
            min_r   <= min_next_s;
        end else if (release_s) begin
            count_r <= 8'd0;
        end
    end

    // Result beat: captured on the closing accept, held until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_max_r   <= '0;
            out_min_r   <= '0;
            out_span_r  <= '0;
        end else if (clear) begin
            out_valid_r <= 1'b0;
        end else if (accept_s && last_s) begin
            out_valid_r <= 1'b1;
            out_max_r   <= max_next_s;
            out_min_r   <= min_next_s;
            out_span_r  <= max_next_s - min_next_s;
        end else if (release_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_max   = out_max_r;
    assign bus.out_min   = out_min_r;
    assign bus.out_span  = out_span_r;
endmodule

// File: tb/tb_window_minmax_tracker.sv
// Self-checking bench: WINDOW=4 tracker driven from a vector table plus corner sequences,
// and a WINDOW=1 instance for the single-sample block case.
module tb_window_minmax_tracker;
    logic clk;
    logic rst_n;
    logic clear;
    logic clear1;

    window_minmax_tracker_if #(.WIDTH(8)) bus ();
    window_minmax_tracker_if #(.WIDTH(8)) bus1 ();

    window_minmax_tracker #(.WIDTH(8), .WINDOW(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus)
    );

    window_minmax_tracker #(.WIDTH(8), .WINDOW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s0, s1, s2, s3;
        int         gap;
        logic [7:0] mx, mn, sp;
    } vec_t;

    typedef struct packed {
        logic [7:0] mx, mn, sp;
    } res_t;

    vec_t vecs[6];
    res_t exp_q[$];
    res_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every taken result beat must match the oldest pushed expectation
    always @(negedge clk) begin
        if (rst_n && !clear && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got max=%0d min=%0d span=%0d want none",
                         bus.out_max, bus.out_min, bus.out_span);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.out_max !== mon_e.mx || bus.out_min !== mon_e.mn || bus.out_span !== mon_e.sp) begin
                    errors++;
                    $display("FAIL result got max=%0d min=%0d span=%0d want max=%0d min=%0d span=%0d",
                             bus.out_max, bus.out_min, bus.out_span, mon_e.mx, mon_e.mn, mon_e.sp);
                end
            end
        end
    end

    // Called and returns at posedge+1; holds in_valid until one accept edge passes
    task automatic send(input logic [7:0] d, input int gap);
        bit done;
        done = 1'b0;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 want 1 data=%0d", d);
        end
    endtask

    task automatic send_window(input vec_t v, input bit push);
        logic [7:0] smp[4];
        smp[0] = v.s0; smp[1] = v.s1; smp[2] = v.s2; smp[3] = v.s3;
        for (int i = 0; i < 3; i++) send(smp[i], v.gap);
        if (push) exp_q.push_back('{mx: v.mx, mn: v.mn, sp: v.sp});
        send(smp[3], v.gap);
    endtask

    // One-cycle result phase with out_ready=1, then back to accepting
    task automatic check_one_cycle_hold(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid_hi"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_in_ready_lo"}, 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_out_valid_lo"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready_hi"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{8'd10,  8'd14,  8'd242, 8'd246, 0, 8'd246, 8'd10,  8'd236};
        vecs[1] = '{8'd100, 8'd100, 8'd100, 8'd100, 0, 8'd100, 8'd100, 8'd0};
        vecs[2] = '{8'd255, 8'd0,   8'd128, 8'd1,   2, 8'd255, 8'd0,   8'd255};
        vecs[3] = '{8'd3,   8'd250, 8'd250, 8'd3,   0, 8'd250, 8'd3,   8'd247};
        vecs[4] = '{8'd0,   8'd0,   8'd0,   8'd0,   0, 8'd0,   8'd0,   8'd0};
        vecs[5] = '{8'd128, 8'd127, 8'd129, 8'd128, 1, 8'd129, 8'd127, 8'd2};

        rst_n = 1'b0; clear = 1'b0; clear1 = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = 8'd0; bus1.out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_max", 32'(bus.out_max), 32'd0);
        chk("rst_out_min", 32'(bus.out_min), 32'd0);
        chk("rst_out_span", 32'(bus.out_span), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            send_window(vecs[i], 1'b1);
            check_one_cycle_hold($sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles while 7 is offered
        bus.out_ready = 1'b0;
        send_window('{8'd30, 8'd200, 8'd5, 8'd90, 0, 8'd200, 8'd5, 8'd195}, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_max", 32'(bus.out_max), 32'd200);
            chk("bp_out_min", 32'(bus.out_min), 32'd5);
            chk("bp_out_span", 32'(bus.out_span), 32'd195);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_after_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_after_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        send(8'd20, 0);
        send(8'd3, 0);
        exp_q.push_back('{mx: 8'd20, mn: 8'd3, sp: 8'd17});
        send(8'd9, 0);
        check_one_cycle_hold("bp_next");

        // clear after two samples, with a sample offered in the clear cycle
        send(8'd50, 0);
        send(8'd60, 0);
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd99;
        @(posedge clk); #1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        send_window('{8'd5, 8'd9, 8'd3, 8'd8, 0, 8'd9, 8'd3, 8'd6}, 1'b1);
        check_one_cycle_hold("clr");

        // clear while holding a result with out_ready=1 discards it
        bus.out_ready = 1'b0;
        send_window('{8'd1, 8'd2, 8'd3, 8'd4, 0, 8'd4, 8'd1, 8'd3}, 1'b0);
        bus.out_ready = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_hold_out_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_hold_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset while holding a result
        bus.out_ready = 1'b0;
        send_window('{8'd40, 8'd70, 8'd20, 8'd60, 0, 8'd70, 8'd20, 8'd50}, 1'b0);
        @(negedge clk);
        chk("hold_before_rst", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_max", 32'(bus.out_max), 32'd0);
        chk("arst_out_min", 32'(bus.out_min), 32'd0);
        chk("arst_out_span", 32'(bus.out_span), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        send_window(vecs[3], 1'b1);
        check_one_cycle_hold("after_rst");

        // WINDOW=1 instance: every sample is its own block
        bus1.in_valid = 1'b1;
        bus1.in_data  = 8'd77;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        chk("w1_out_valid", 32'(bus1.out_valid), 32'd1);
        chk("w1_out_max", 32'(bus1.out_max), 32'd77);
        chk("w1_out_min", 32'(bus1.out_min), 32'd77);
        chk("w1_out_span", 32'(bus1.out_span), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w1_out_valid_lo", 32'(bus1.out_valid), 32'd0);
        @(posedge clk); #1;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 8'd200;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        chk("w1b_out_max", 32'(bus1.out_max), 32'd200);
        chk("w1b_out_min", 32'(bus1.out_min), 32'd200);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
